// File: rtl/inst_axi_bridge_pkg.sv
// Shared state encoding and fixed AXI read-channel field values for the instruction bridge.
package inst_axi_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam logic [7:0]  ArLen           = 8'd0;
  localparam logic [1:0]  ArBurstIncr     = 2'b01;
  localparam logic [1:0]  ArLock          = 2'b00;
  localparam logic [2:0]  ArProt          = 3'b000;
  localparam logic [3:0]  ArcacheUncached = 4'b0000;
  localparam logic [1:0]  SizeWord        = 2'b10;
  localparam logic [1:0]  RespOkay        = 2'b00;
  localparam logic [31:0] ZeroWord        = 32'h0000_0000;

  // Word fetches go out word-aligned; narrower sizes keep the byte offset.
  function automatic logic [31:0] align_addr(logic [31:0] addr, logic [1:0] size);
    return (size == SizeWord) ? {addr[31:2], 2'b00} : addr;
  endfunction

endpackage

// File: rtl/inst_axi_bridge.sv
// SRAM-like instruction port to single-beat AXI read bridge; one request outstanding at a time.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ARID           = 4'd0,
  parameter logic [3:0] CACHED_ARCACHE = 4'b1111
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_cache,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        cache_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        data_ok_q;
  logic        beat_done;
  logic        read_hs;
  logic        write_hs;

  // Writes are acknowledged without data; every beat is single so rlast carries nothing.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wdata, rlast};

  always_comb begin
    state_d      = state_q;
    inst_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    beat_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        inst_addr_ok = inst_req;
        if (inst_req && !inst_wr) state_d = StAddr;
      end
      StAddr: begin
        arvalid = 1'b1;
        if (arready) state_d = StData;
      end
      StData: begin
        rready = 1'b1;
        if (rvalid && (rid == ARID)) begin
          beat_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign read_hs  = inst_req && inst_addr_ok && !inst_wr;
  assign write_hs = inst_req && inst_addr_ok && inst_wr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= ZeroWord;
      size_q    <= 2'b00;
      cache_q   <= 1'b0;
      rdata_q   <= ZeroWord;
      err_q     <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_ok_q <= beat_done || write_hs;
      if (read_hs) begin
        addr_q  <= inst_addr;
        size_q  <= inst_size;
        cache_q <= inst_cache;
      end
      if (beat_done) begin
        rdata_q <= rdata;
        err_q   <= (rresp != RespOkay);
      end else if (write_hs) begin
        rdata_q <= ZeroWord;
        err_q   <= 1'b0;
      end
    end
  end

  assign inst_data_ok = data_ok_q;
  assign inst_rdata   = rdata_q;
  assign inst_bus_err = err_q;

  assign arid    = ARID;
  assign araddr  = align_addr(addr_q, size_q);
  assign arlen   = ArLen;
  assign arsize  = {1'b0, size_q};
  assign arburst = ArBurstIncr;
  assign arlock  = ArLock;
  assign arcache = cache_q ? CACHED_ARCACHE : ArcacheUncached;
  assign arprot  = ArProt;

endmodule
